// File: rtl/ooo_pkg.sv
// Shared types and sizing for the rename stage and the ROB dispatch interface.
//   arch_reg_t     : architectural register index
//   phys_reg_t     : physical register index
//   rob_tag_t      : ROB entry tag
//   dispatch_pkt_t : registered packet handed from rename to the ROB
package ooo_pkg;

  localparam int ARCH_REGS   = 32;
  localparam int PHYS_REGS   = 64;
  localparam int ROB_ENTRIES = 64;
  localparam int TAG_WIDTH   = 6;
  localparam int ARCH_W      = $clog2(ARCH_REGS);
  localparam int FL_CNT_W    = $clog2(PHYS_REGS) + 1;
  localparam int CREDIT_W    = $clog2(ROB_ENTRIES) + 1;

  typedef logic [ARCH_W-1:0]    arch_reg_t;
  typedef logic [TAG_WIDTH-1:0] phys_reg_t;
  typedef logic [TAG_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic      valid;
    rob_tag_t  tag;
    phys_reg_t phys_reg;
    phys_reg_t old_phys_reg;
    phys_reg_t prs1;
    phys_reg_t prs2;
    logic      is_load;
    logic      is_store;
  } dispatch_pkt_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   push, push_reg    : return a register at the tail (ignored when full)
//   pop               : consume the head entry (ignored when empty)
//   head_reg          : register at the head, valid when !empty
//   empty, full, count: occupancy status
// Reset preloads ARCH_REGS..PHYS_REGS-1, since x0..x31 start mapped 1:1.
// A pushed register only becomes visible at the head after the edge that
// writes it, so there is no same-cycle push-to-pop bypass.
module free_list
  import ooo_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  phys_reg_t           push_reg,
  input  logic                pop,
  output phys_reg_t           head_reg,
  output logic                empty,
  output logic                full,
  output logic [FL_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(PHYS_REGS);

  phys_reg_t        mem [PHYS_REGS];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FL_CNT_W'(PHYS_REGS));
  assign head_reg = mem[head];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? phys_reg_t'(ARCH_REGS + i) : '0;
      end
      head  <= '0;
      tail  <= PTR_W'(PHYS_REGS - ARCH_REGS);
      count <= FL_CNT_W'(PHYS_REGS - ARCH_REGS);
    end else begin
      if (do_push) begin
        mem[tail] <= push_reg;
        tail      <= (tail == PTR_W'(PHYS_REGS - 1)) ? '0 : tail + 1'b1;
      end
      if (do_pop) begin
        head <= (head == PTR_W'(PHYS_REGS - 1)) ? '0 : head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rename_unit.sv
// Single-issue register rename stage feeding the reorder buffer.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   dec_*                          : decoded instruction in, dec_ready out
//   dispatch_*                     : registered one-cycle packet to the ROB
//   rob_commit_valid               : ROB retired an entry, returns a credit
//   free_valid, free_phys_reg      : physical register returned at commit
// The credit counter mirrors ROB occupancy, so a dispatch pulse never needs
// a ready/back-pressure signal from the ROB.
module rename_unit
  import ooo_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      dec_valid,
  output logic      dec_ready,
  input  arch_reg_t dec_rs1,
  input  arch_reg_t dec_rs2,
  input  arch_reg_t dec_rd,
  input  logic      dec_rd_wen,
  input  logic      dec_is_load,
  input  logic      dec_is_store,
  output logic      dispatch_valid,
  output rob_tag_t  dispatch_tag,
  output phys_reg_t dispatch_phys_reg,
  output phys_reg_t dispatch_old_phys_reg,
  output phys_reg_t dispatch_prs1,
  output phys_reg_t dispatch_prs2,
  output logic      dispatch_is_load,
  output logic      dispatch_is_store,
  input  logic      rob_commit_valid,
  input  logic      free_valid,
  input  phys_reg_t free_phys_reg
);

  phys_reg_t           rat [ARCH_REGS];
  logic [CREDIT_W-1:0] credits;
  rob_tag_t            tag_cnt;
  dispatch_pkt_t       disp_q;

  phys_reg_t           fl_head;
  logic                fl_empty;
  logic                fl_full;
  logic [FL_CNT_W-1:0] fl_count;
  logic                fl_push;

  logic                accept;
  logic                alloc;
  logic                credit_max;
  phys_reg_t           prs1;
  phys_reg_t           prs2;

  // Ready is built from registered state only, so it cannot loop back
  // through the decoder's valid.
  assign dec_ready  = (credits != '0) && (fl_count != '0);
  assign accept     = dec_valid && dec_ready;
  assign alloc      = accept && dec_rd_wen && (dec_rd != '0);
  assign credit_max = (credits == CREDIT_W'(ROB_ENTRIES));
  assign fl_push    = free_valid && (free_phys_reg != '0);

  // Sources read the pre-write RAT, so rs == rd sees the old mapping.
  assign prs1 = (dec_rs1 == '0) ? '0 : rat[dec_rs1];
  assign prs2 = (dec_rs2 == '0) ? '0 : rat[dec_rs2];

  free_list u_free_list (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fl_push),
    .push_reg (free_phys_reg),
    .pop      (alloc),
    .head_reg (fl_head),
    .empty    (fl_empty),
    .full     (fl_full),
    .count    (fl_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        rat[a] <= phys_reg_t'(a);
      end
    end else if (alloc) begin
      rat[dec_rd] <= fl_head;
    end
  end

  // An accept and a commit in the same cycle cancel; a lone commit at full
  // credit is dropped rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CREDIT_W'(ROB_ENTRIES);
      tag_cnt <= '0;
    end else begin
      if (accept && !rob_commit_valid) begin
        credits <= credits - 1'b1;
      end else if (!accept && rob_commit_valid && !credit_max) begin
        credits <= credits + 1'b1;
      end
      if (accept) begin
        tag_cnt <= tag_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else begin
      disp_q.valid <= accept;
      if (accept) begin
        disp_q.tag          <= tag_cnt;
        disp_q.phys_reg     <= alloc ? fl_head : '0;
        disp_q.old_phys_reg <= alloc ? rat[dec_rd] : '0;
        disp_q.prs1         <= prs1;
        disp_q.prs2         <= prs2;
        disp_q.is_load      <= dec_is_load;
        disp_q.is_store     <= dec_is_store;
      end
    end
  end

  assign dispatch_valid        = disp_q.valid;
  assign dispatch_tag          = disp_q.tag;
  assign dispatch_phys_reg     = disp_q.phys_reg;
  assign dispatch_old_phys_reg = disp_q.old_phys_reg;
  assign dispatch_prs1         = disp_q.prs1;
  assign dispatch_prs2         = disp_q.prs2;
  assign dispatch_is_load      = disp_q.is_load;
  assign dispatch_is_store     = disp_q.is_store;

  a_commit_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(rob_commit_valid && !accept && credit_max));

  a_free_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(fl_push && fl_full));

  a_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(alloc && fl_empty));

endmodule
